stage_id: RTL and testbench
===========================

// Module: stage_id
// PURPOSE
//  Instruction-decode stage directly downstream of stage_if. Holds the IF/ID pipeline
//  register, the 32x32 register file (written back from WB), immediate sign-extension
//  and load-use hazard detection. Produces operands for EX and a stall back to IF/PC.
// PARAMETERS
//  DATA_WIDTH  32            register and instruction word width
//  REG_ADDR_W  5             register index width (2**REG_ADDR_W registers)
//  NOP_WORD    32'h00000000  instruction injected on flush/reset (sll $0,$0,0)
// PORTS
//  clock             in   1   rising-edge clock
//  reset             in   1   synchronous, active-high reset
//  if_instruction    in   32  fetched word from stage_if
//  if_iadd           in   32  address of fetched word
//  control_flush     in   1   taken branch/jump: discard the instruction in IF/ID
//  wb_reg_write      in   1   WB write enable
//  wb_write_reg      in   5   WB destination register
//  wb_write_data     in   32  WB data
//  ex_mem_read       in   1   instruction now in EX is a load
//  ex_write_reg      in   5   destination register of instruction in EX
//  stall             out  1   hold PC and IF outputs this cycle
//  id_valid          out  1   ID holds a real instruction for EX (0 = bubble)
//  id_instruction    out  32  latched instruction
//  id_iadd           out  32  latched instruction address
//  data_rs           out  32  register[instr[25:21]] (with WB bypass)
//  data_rt           out  32  register[instr[20:16]] (with WB bypass)
//  data_imm          out  32  sign-extended instr[15:0]
//  rs, rt, rd        out  5   instr[25:21], instr[20:16], instr[15:11]
// BEHAVIOUR
//  IF/ID latch (registered, updated on rising edge):
//   - reset: id_instruction=NOP_WORD, id_iadd=0, latch_valid=0.
//   - else if control_flush: load NOP_WORD, latch_valid=0 (flush beats stall).
//   - else if stall: hold all latch contents.
//   - else: load if_instruction/if_iadd, latch_valid=1.
//  Register file: 2**REG_ADDR_W x DATA_WIDTH.
//   - reset clears every entry to 0 in that edge.
//   - write at rising edge when wb_reg_write && wb_write_reg!=0; writes to r0 ignored,
//     r0 always reads 0.
//   - reads combinational from latched rs/rt; same-cycle WB to a read register
//     (wb_reg_write, index match, index!=0) bypasses: output = wb_write_data.
//  data_imm = {{16{instr[15]}}, instr[15:0]}; rs/rt/rd pure slices of id_instruction.
//  Hazard: stall = latch_valid && ex_mem_read && ex_write_reg!=0 &&
//          (ex_write_reg==rs || ex_write_reg==rt); combinational, 0 during reset.
//  id_valid = latch_valid && !stall (EX must insert bubble when 0).
//  Latency: instruction presented on if_instruction appears on id_* one edge later;
//   operands valid in the same cycle as id_instruction.
//  A stall lasts exactly one cycle per load-use pair (EX advances a bubble).
//  control_flush and stall in same cycle: latch takes NOP, stall output still as computed.
//  Reset mid-operation: next edge latch=NOP, regfile zeroed, stall=0, id_valid=0.
// TESTING
//  1 reset 2 cycles -> id_instruction=0, id_valid=0, stall=0, all regs read 0.
//  2 WB write r5=32'hDEADBEEF, then instr 0x00A53020 (add r6,r5,r5) -> data_rs=data_rt=DEADBEEF.
//  3 WB writes r8=0x12 same cycle ID reads r8 -> data_rs=0x12 (bypass); write r0=0xFF -> reads 0.
//  4 ex_mem_read=1, ex_write_reg=9, ID rs=9 -> stall=1, id_valid=0, latch holds 1 cycle,
//    if_instruction change ignored; next cycle ex_mem_read=0 -> stall=0, new word latched.
//  5 control_flush=1 with stall condition active -> next edge id_instruction=0, id_valid=0.
//  6 instr imm 0x8000 -> data_imm=32'hFFFF8000; imm 0x7FFF -> 32'h00007FFF.

Source files
------------

// File: rtl/stage_id.sv
// Instruction-decode stage: IF/ID pipeline latch, register file with
// write-back bypass, immediate sign-extension and load-use hazard detection.
//
// Handshake: stall is a hold request back to IF/PC. While stall=1, IF keeps
// its outputs and this stage keeps its latch. id_valid qualifies every id_*
// and operand output for EX. EX consumes the instruction only on a cycle with
// id_valid=1 and inserts a bubble on any cycle with id_valid=0.
module stage_id #(
   parameter int                DATA_WIDTH = 32,
   parameter int                REG_ADDR_W = 5,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD = 32'h00000000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] if_instruction,
   input  logic [DATA_WIDTH-1:0] if_iadd,
   input  logic                  control_flush,
   input  logic                  wb_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_write_reg,
   input  logic [DATA_WIDTH-1:0] wb_write_data,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_write_reg,
   output logic                  stall,
   output logic                  id_valid,
   output logic [DATA_WIDTH-1:0] id_instruction,
   output logic [DATA_WIDTH-1:0] id_iadd,
   output logic [DATA_WIDTH-1:0] data_rs,
   output logic [DATA_WIDTH-1:0] data_rt,
   output logic [DATA_WIDTH-1:0] data_imm,
   output logic [REG_ADDR_W-1:0] rs,
   output logic [REG_ADDR_W-1:0] rt,
   output logic [REG_ADDR_W-1:0] rd
);

   localparam int NREGS = 2**REG_ADDR_W;

   logic [DATA_WIDTH-1:0] instr_q;
   logic [DATA_WIDTH-1:0] iadd_q;
   logic                  latch_valid;
   logic [DATA_WIDTH-1:0] regs [0:NREGS-1];

   // IF/ID latch: flush has priority over stall, stall holds everything.
   always_ff @(posedge clock) begin
      if (reset) begin
         instr_q     <= NOP_WORD;
         iadd_q      <= '0;
         latch_valid <= 1'b0;
      end else if (control_flush) begin
         instr_q     <= NOP_WORD;
         latch_valid <= 1'b0;
      end else if (!stall) begin
         instr_q     <= if_instruction;
         iadd_q      <= if_iadd;
         latch_valid <= 1'b1;
      end
   end

   // Register file: cleared on reset, written from WB; r0 is never written.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_reg_write && (wb_write_reg != '0)) begin
         regs[wb_write_reg] <= wb_write_data;
      end
   end

   // Field slices of the latched instruction.
   always_comb begin
      rs = instr_q[21 +: REG_ADDR_W];
      rt = instr_q[16 +: REG_ADDR_W];
      rd = instr_q[11 +: REG_ADDR_W];
   end

   // Operand reads: r0 reads zero, a same-cycle WB to the read index bypasses.
   always_comb begin
      data_rs = '0;
      data_rt = '0;
      if (rs != '0) begin
         if (wb_reg_write && (wb_write_reg == rs)) data_rs = wb_write_data;
         else                                      data_rs = regs[rs];
      end
      if (rt != '0) begin
         if (wb_reg_write && (wb_write_reg == rt)) data_rt = wb_write_data;
         else                                      data_rt = regs[rt];
      end
   end

   // Immediate sign-extension of the low half-word.
   always_comb begin
      data_imm = {{(DATA_WIDTH-16){instr_q[15]}}, instr_q[15:0]};
   end

   // Load-use hazard: a load in EX writing a register this instruction reads.
   always_comb begin
      stall = !reset && latch_valid && ex_mem_read && (ex_write_reg != '0) &&
              ((ex_write_reg == rs) || (ex_write_reg == rt));
      id_valid = latch_valid && !stall;
   end

   assign id_instruction = instr_q;
   assign id_iadd        = iadd_q;

endmodule

// File: tb/tb_stage_id.sv
// Directed bench for stage_id: reset, write-back/read, bypass, r0,
// load-use stall, flush-over-stall, immediates and mid-run reset.
module tb_stage_id;

   logic        clk;
   logic        reset;
   logic [31:0] if_instruction;
   logic [31:0] if_iadd;
   logic        control_flush;
   logic        wb_reg_write;
   logic [4:0]  wb_write_reg;
   logic [31:0] wb_write_data;
   logic        ex_mem_read;
   logic [4:0]  ex_write_reg;
   logic        stall;
   logic        id_valid;
   logic [31:0] id_instruction;
   logic [31:0] id_iadd;
   logic [31:0] data_rs;
   logic [31:0] data_rt;
   logic [31:0] data_imm;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;

   int checks = 0;
   int errors = 0;

   stage_id dut (
      .clock          (clk),
      .reset          (reset),
      .if_instruction (if_instruction),
      .if_iadd        (if_iadd),
      .control_flush  (control_flush),
      .wb_reg_write   (wb_reg_write),
      .wb_write_reg   (wb_write_reg),
      .wb_write_data  (wb_write_data),
      .ex_mem_read    (ex_mem_read),
      .ex_write_reg   (ex_write_reg),
      .stall          (stall),
      .id_valid       (id_valid),
      .id_instruction (id_instruction),
      .id_iadd        (id_iadd),
      .data_rs        (data_rs),
      .data_rt        (data_rt),
      .data_imm       (data_imm),
      .rs             (rs),
      .rt             (rt),
      .rd             (rd)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and move 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after an input change.
   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      reset          = 1'b1;
      if_instruction = 32'h0;
      if_iadd        = 32'h0;
      control_flush  = 1'b0;
      wb_reg_write   = 1'b0;
      wb_write_reg   = 5'd0;
      wb_write_data  = 32'h0;
      ex_mem_read    = 1'b0;
      ex_write_reg   = 5'd0;

      // 1: reset for two cycles
      step();
      step();
      chk("rst_instr", id_instruction, 32'h0);
      chk("rst_iadd", id_iadd, 32'h0);
      chk("rst_valid", {31'b0, id_valid}, 32'h0);
      chk("rst_stall", {31'b0, stall}, 32'h0);
      chk("rst_rs", data_rs, 32'h0);
      chk("rst_rt", data_rt, 32'h0);

      // 2: write r5 while latching add r6,r5,r5
      reset          = 1'b0;
      wb_reg_write   = 1'b1;
      wb_write_reg   = 5'd5;
      wb_write_data  = 32'hDEADBEEF;
      if_instruction = 32'h00A53020;
      if_iadd        = 32'h00000100;
      step();
      wb_reg_write   = 1'b0;
      settle();
      chk("add_instr", id_instruction, 32'h00A53020);
      chk("add_iadd", id_iadd, 32'h00000100);
      chk("add_rs_idx", {27'b0, rs}, 32'd5);
      chk("add_rt_idx", {27'b0, rt}, 32'd5);
      chk("add_rd_idx", {27'b0, rd}, 32'd6);
      chk("add_data_rs", data_rs, 32'hDEADBEEF);
      chk("add_data_rt", data_rt, 32'hDEADBEEF);
      chk("add_imm", data_imm, 32'h00003020);
      chk("add_valid", {31'b0, id_valid}, 32'h1);

      // 3: bypass on r8, then r0 writes ignored
      if_instruction = 32'h01000000;   // rs=8, rt=0
      if_iadd        = 32'h00000104;
      step();
      wb_reg_write   = 1'b1;
      wb_write_reg   = 5'd8;
      wb_write_data  = 32'h00000012;
      settle();
      chk("byp_rs", data_rs, 32'h00000012);
      chk("byp_rt_r0", data_rt, 32'h0);
      step();                            // r8 written, same word relatched
      wb_write_reg   = 5'd0;
      wb_write_data  = 32'h000000FF;
      settle();
      chk("r8_stored", data_rs, 32'h00000012);
      chk("r0_bypass", data_rt, 32'h0);
      step();
      wb_reg_write   = 1'b0;
      settle();
      chk("r0_after", data_rt, 32'h0);

      // 4: load-use stall on rs=9
      wb_reg_write   = 1'b1;
      wb_write_reg   = 5'd9;
      wb_write_data  = 32'h00000099;
      if_instruction = 32'h012A0000;   // rs=9, rt=10
      if_iadd        = 32'h00000108;
      step();
      wb_reg_write   = 1'b0;
      ex_mem_read    = 1'b1;
      ex_write_reg   = 5'd9;
      if_instruction = 32'h11111111;   // rs=8, rt=17
      if_iadd        = 32'h0000010C;
      settle();
      chk("lu_stall", {31'b0, stall}, 32'h1);
      chk("lu_valid", {31'b0, id_valid}, 32'h0);
      step();
      ex_mem_read    = 1'b0;
      settle();
      chk("lu_hold", id_instruction, 32'h012A0000);
      chk("lu_hold_iadd", id_iadd, 32'h00000108);
      chk("lu_release", {31'b0, stall}, 32'h0);
      chk("lu_valid2", {31'b0, id_valid}, 32'h1);
      chk("lu_data_rs", data_rs, 32'h00000099);
      step();
      chk("lu_new", id_instruction, 32'h11111111);
      chk("lu_new_iadd", id_iadd, 32'h0000010C);
      ex_write_reg   = 5'd8;           // match without a load: no stall
      settle();
      chk("nolo_stall", {31'b0, stall}, 32'h0);

      // 5: flush with stall condition (rt=17) active
      ex_mem_read    = 1'b1;
      ex_write_reg   = 5'd17;
      control_flush  = 1'b1;
      if_instruction = 32'h22222222;
      settle();
      chk("fl_stall", {31'b0, stall}, 32'h1);
      step();
      chk("fl_instr", id_instruction, 32'h0);
      chk("fl_valid", {31'b0, id_valid}, 32'h0);
      chk("fl_stall2", {31'b0, stall}, 32'h0);

      // 6: immediates
      control_flush  = 1'b0;
      ex_mem_read    = 1'b0;
      if_instruction = 32'h00008000;
      step();
      chk("imm_neg", data_imm, 32'hFFFF8000);
      chk("imm_valid", {31'b0, id_valid}, 32'h1);
      if_instruction = 32'h00007FFF;
      step();
      chk("imm_pos", data_imm, 32'h00007FFF);

      // 7: reset mid-operation
      if_instruction = 32'h00A53020;
      step();
      ex_mem_read    = 1'b1;
      ex_write_reg   = 5'd5;
      settle();
      chk("mr_pre_stall", {31'b0, stall}, 32'h1);
      reset          = 1'b1;
      settle();
      chk("mr_stall_rst", {31'b0, stall}, 32'h0);
      step();
      reset          = 1'b0;
      ex_mem_read    = 1'b0;
      settle();
      chk("mr_instr", id_instruction, 32'h0);
      chk("mr_valid", {31'b0, id_valid}, 32'h0);
      step();                            // relatch add r6,r5,r5
      chk("mr_relatch", id_instruction, 32'h00A53020);
      chk("mr_r5_zero", data_rs, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
